// File: rtl/fix_tx_serializer_if.sv
// FIFO read port and byte-wide transmit handshake of the FIX message serializer.
// The master modport is the serializer; the slave modport is its FIFO/transmit environment.
interface fix_tx_serializer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  empty_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  rd_cs_o;
    logic                  rd_en_o;
    logic [7:0]            tx_data_o;
    logic                  tx_valid_o;
    logic                  tx_ready_i;
    logic                  tx_last_o;
    logic                  busy_o;
    logic                  msg_done_o;
    logic [7:0]            checksum_o;

    modport master (
        input  empty_i, data_i, tx_ready_i,
        output rd_cs_o, rd_en_o, tx_data_o, tx_valid_o, tx_last_o,
               busy_o, msg_done_o, checksum_o
    );

    modport slave (
        output empty_i, data_i, tx_ready_i,
        input  rd_cs_o, rd_en_o, tx_data_o, tx_valid_o, tx_last_o,
               busy_o, msg_done_o, checksum_o
    );
endinterface

// File: rtl/fix_tx_serializer.sv
// Pops length-prefixed FIX message words from the FIFO, emits them big-endian as bytes
// and appends the "10=NNN<SOH>" checksum trailer.
module fix_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter logic [7:0]  SOH        = 8'h01
) (
    input logic                 clk,
    input logic                 rst,
    fix_tx_serializer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_WAIT,
        PAY_RD,
        PAY_WAIT,
        SEND,
        TRL
    } state_t;

    state_t                state;
    logic                  rd_en_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [1:0]            byte_idx;
    logic [2:0]            trl_idx;
    logic [7:0]            checksum;
    logic [7:0]            trl_byte;
    logic [7:0]            dig_hund;
    logic [7:0]            dig_tens;
    logic [7:0]            dig_ones;
    logic                  accept;

    assign bus.rd_en_o = rd_en_q;
    assign bus.rd_cs_o = rd_en_q;
    assign accept      = bus.tx_valid_o && bus.tx_ready_i;

    // trl_idx always names the trailer byte to present after the current one is accepted.
    always_comb begin
        dig_hund = checksum / 8'd100;
        dig_tens = (checksum / 8'd10) % 8'd10;
        dig_ones = checksum % 8'd10;
        trl_byte = SOH;
        case (trl_idx)
            3'd0:    trl_byte = 8'h31;
            3'd1:    trl_byte = 8'h30;
            3'd2:    trl_byte = 8'h3D;
            3'd3:    trl_byte = 8'h30 + dig_hund;
            3'd4:    trl_byte = 8'h30 + dig_tens;
            3'd5:    trl_byte = 8'h30 + dig_ones;
            default: trl_byte = SOH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rd_en_q        <= 1'b0;
            word_q         <= '0;
            remaining      <= '0;
            byte_idx       <= '0;
            trl_idx        <= '0;
            checksum       <= '0;
            bus.tx_data_o  <= '0;
            bus.tx_valid_o <= 1'b0;
            bus.tx_last_o  <= 1'b0;
            bus.busy_o     <= 1'b0;
            bus.msg_done_o <= 1'b0;
            bus.checksum_o <= '0;
        end else begin
            bus.msg_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.empty_i) begin
                        rd_en_q    <= 1'b1;
                        bus.busy_o <= 1'b1;
                        state      <= HDR_RD;
                    end
                end
                HDR_RD: begin
                    rd_en_q <= 1'b0;
                    state   <= HDR_WAIT;
                end
                HDR_WAIT: begin
                    remaining <= bus.data_i[LEN_WIDTH-1:0];
                    checksum  <= '0;
                    if (bus.data_i[LEN_WIDTH-1:0] == '0) begin
                        bus.tx_data_o  <= 8'h31;
                        bus.tx_valid_o <= 1'b1;
                        trl_idx        <= 3'd1;
                        state          <= TRL;
                    end else begin
                        rd_en_q <= !bus.empty_i;
                        state   <= PAY_RD;
                    end
                end
                // A pop may already be in flight on entry; otherwise wait here for data.
                PAY_RD: begin
                    if (rd_en_q) begin
                        rd_en_q <= 1'b0;
                        state   <= PAY_WAIT;
                    end else if (!bus.empty_i) begin
                        rd_en_q <= 1'b1;
                    end
                end
                PAY_WAIT: begin
                    word_q         <= bus.data_i;
                    byte_idx       <= '0;
                    bus.tx_data_o  <= bus.data_i[DATA_WIDTH-1 -: 8];
                    bus.tx_valid_o <= 1'b1;
                    state          <= SEND;
                end
                SEND: begin
                    if (accept) begin
                        checksum  <= checksum + bus.tx_data_o;
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            bus.tx_data_o <= 8'h31;
                            trl_idx       <= 3'd1;
                            state         <= TRL;
                        end else if (byte_idx == 2'd3) begin
                            bus.tx_valid_o <= 1'b0;
                            rd_en_q        <= !bus.empty_i;
                            state          <= PAY_RD;
                        end else begin
                            byte_idx      <= byte_idx + 2'd1;
                            bus.tx_data_o <= word_q[DATA_WIDTH-9 -: 8];
                            word_q        <= {word_q[DATA_WIDTH-9:0], 8'h00};
                        end
                    end
                end
                TRL: begin
                    if (accept) begin
                        if (bus.tx_last_o) begin
                            bus.tx_valid_o <= 1'b0;
                            bus.tx_last_o  <= 1'b0;
                            bus.busy_o     <= 1'b0;
                            bus.msg_done_o <= 1'b1;
                            bus.checksum_o <= checksum;
                            state          <= IDLE;
                        end else begin
                            bus.tx_data_o <= trl_byte;
                            bus.tx_last_o <= (trl_idx == 3'd6);
                            trl_idx       <= trl_idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_tx_serializer.sv
// Directed bench for fix_tx_serializer: FIFO model, byte monitor and hand-computed
// byte sequences and checksums for each message.
module tb_fix_tx_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fix_tx_serializer_if #(.DATA_WIDTH(32)) bus ();

    fix_tx_serializer #(
        .DATA_WIDTH(32),
        .LEN_WIDTH (16),
        .SOH       (8'h01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.empty_i = (wr_ptr == rd_ptr);

    logic [7:0] byte_q [$];
    int         last_q [$];
    int         pops      = 0;
    int         bad_pops  = 0;
    int         done_cnt  = 0;
    int         hold_viol = 0;
    logic [7:0] done_cs   = 8'h00;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    logic [7:0] exp_t1 [$] = '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58,
                               8'h31, 8'h30, 8'h3D, 8'h30, 8'h39, 8'h32, 8'h01};
    logic [7:0] exp_t2 [$] = '{8'h31, 8'h30, 8'h3D, 8'h30, 8'h30, 8'h30, 8'h01};
    logic [7:0] exp_t3 [$] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h31, 8'h30, 8'h3D, 8'h32, 8'h35, 8'h32, 8'h01};
    logic [7:0] exp_t6 [$] = '{8'h41, 8'h31, 8'h30, 8'h3D, 8'h30, 8'h36, 8'h35, 8'h01};

    // FIFO read side and transmit monitor, both sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.rd_en_o) begin
            pops++;
            if (bus.empty_i || !bus.rd_cs_o) begin
                bad_pops++;
            end else begin
                bus.data_i = mem[rd_ptr % 64];
                rd_ptr++;
            end
        end
        if (prev_stall && !rst &&
            (!bus.tx_valid_o || bus.tx_data_o != prev_data || bus.tx_last_o != prev_last))
            hold_viol++;
        prev_stall = bus.tx_valid_o && !bus.tx_ready_i && !rst;
        prev_data  = bus.tx_data_o;
        prev_last  = bus.tx_last_o;
        if (bus.tx_valid_o && bus.tx_ready_i) begin
            if (bus.tx_last_o) last_q.push_back(byte_q.size());
            byte_q.push_back(bus.tx_data_o);
        end
        if (bus.msg_done_o) begin
            done_cnt++;
            done_cs = bus.checksum_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic clear_log();
        byte_q.delete();
        last_q.delete();
    endtask

    task automatic finish_msg(input string name, input logic [7:0] exp[$], input logic [7:0] cs,
                              input int exp_pops, input int pops0, input int done0);
        logic [31:0] got;
        int          last_at;
        for (int i = 0; i < 400 && done_cnt == done0; i++) tick();
        check({name, "_done_seen"}, 32'(done_cnt != done0), 32'd1);
        repeat (3) tick();
        check({name, "_done_pulses"}, 32'(done_cnt - done0), 32'd1);
        check({name, "_checksum"}, 32'(done_cs), 32'(cs));
        check({name, "_len"}, 32'(byte_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < byte_q.size()) ? 32'(byte_q[i]) : 'x;
            check($sformatf("%s_byte%0d", name, i), got, 32'(exp[i]));
        end
        last_at = (last_q.size() > 0) ? last_q[0] : -1;
        check({name, "_last_count"}, 32'(last_q.size()), 32'd1);
        check({name, "_last_pos"}, 32'(last_at), 32'(exp.size() - 1));
        check({name, "_pops"}, 32'(pops - pops0), 32'(exp_pops));
    endtask

    initial begin
        int p0;
        int d0;
        int viol;
        bit found;

        rst            = 1'b1;
        bus.tx_ready_i = 1'b1;
        repeat (3) tick();
        check("rst_ctl", {26'd0, bus.rd_en_o, bus.rd_cs_o, bus.tx_valid_o, bus.tx_last_o,
                          bus.busy_o, bus.msg_done_o}, 32'd0);
        check("rst_data", {16'd0, bus.tx_data_o, bus.checksum_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic 5-byte message spanning two words
        clear_log(); p0 = pops; d0 = done_cnt;
        push_word(32'h0000_0005); push_word(32'h383D_4649); push_word(32'h5800_0000);
        finish_msg("t1", exp_t1, 8'h5C, 3, p0, d0);

        // Empty message: header only
        clear_log(); p0 = pops; d0 = done_cnt;
        push_word(32'h0000_0000);
        finish_msg("t2", exp_t2, 8'h00, 1, p0, d0);

        // Upper header bits ignored, checksum wraps
        clear_log(); p0 = pops; d0 = done_cnt;
        push_word(32'hABCD_0004); push_word(32'hFFFF_FFFF);
        finish_msg("t3", exp_t3, 8'hFC, 2, p0, d0);

        // Backpressure on byte 0x46
        clear_log(); p0 = pops; d0 = done_cnt;
        push_word(32'h0000_0005); push_word(32'h383D_4649); push_word(32'h5800_0000);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus.tx_valid_o && bus.tx_data_o == 8'h46) found = 1'b1;
            else tick();
        end
        check("t4_found_46", 32'(found), 32'd1);
        bus.tx_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t4_hold%0d", k), {23'd0, bus.tx_valid_o, bus.tx_data_o}, 32'h146);
        end
        bus.tx_ready_i = 1'b1;
        finish_msg("t4", exp_t1, 8'h5C, 3, p0, d0);

        // FIFO empty between header and first payload word
        clear_log(); p0 = pops; d0 = done_cnt;
        push_word(32'h0000_0005);
        for (int i = 0; i < 50 && pops == p0; i++) tick();
        viol = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.rd_en_o || bus.tx_valid_o) viol++;
        end
        check("t5_stall_quiet", 32'(viol), 32'd0);
        check("t5_one_pop", 32'(pops - p0), 32'd1);
        push_word(32'h383D_4649); push_word(32'h5800_0000);
        finish_msg("t5", exp_t1, 8'h5C, 3, p0, d0);

        // Reset while the second payload byte is presented
        clear_log(); d0 = done_cnt;
        push_word(32'h0000_0005); push_word(32'h383D_4649); push_word(32'h5800_0000);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (bus.tx_valid_o && bus.tx_data_o == 8'h3D) found = 1'b1;
            else tick();
        end
        check("t6_found_3d", 32'(found), 32'd1);
        rst    = 1'b1;
        wr_ptr = rd_ptr;
        tick();
        check("t6_after_rst", {29'd0, bus.tx_valid_o, bus.busy_o, bus.rd_en_o}, 32'd0);
        rst = 1'b0;
        tick();
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        clear_log(); p0 = pops; d0 = done_cnt;
        push_word(32'h0000_0001); push_word(32'h4100_0000);
        finish_msg("t6", exp_t6, 8'h41, 2, p0, d0);

        check("pop_on_empty", 32'(bad_pops), 32'd0);
        check("hold_stable", 32'(hold_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
